systolic_ctrl: RTL and testbench

Sequencer for the 32x32 systolic multiply array. It accepts a job of one or more tiles and, for each tile, prefetches weight/input operands from SRAM. It then drives the array's alu_start, cycle_num and matrix_index inputs, and flags the cycles in which mul_outcome holds a valid output diagonal. It sits between the TPU top-level command logic and the systolic array plus its operand SRAMs.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/systolic_addr_gen.sv | 64 ++++++
 rtl/systolic_ctrl.sv | 134 +++++++++++++
 tb/tb_systolic_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and state encodings for the systolic array sequencer.
package tpu_pkg;
    localparam int ARRAY_SIZE = 32;
    localparam int FIRST_OUT  = 33;
    localparam int LAST       = FIRST_OUT + 2*ARRAY_SIZE - 1;
    localparam int CYCLE_W    = 9;
    localparam int IDX_W      = 6;

    typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DONE} state_t;

    // What the address generator should present on the SRAM port next cycle
    typedef enum logic [1:0] {AG_OFF, AG_PF, AG_RD, AG_HOLD} ag_mode_t;
endpackage

// File: rtl/systolic_addr_gen.sv
// Operand SRAM read address generation: latched job base, per-tile offset
// (stepped by ARRAY_SIZE, no multiplier) and per-cycle registered address.
module systolic_addr_gen
    import tpu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_base,
    input  logic               i_adv,
    input  ag_mode_t           i_mode,
    input  logic [CYCLE_W-1:0] i_cycle,
    output logic               o_ren,
    output logic [ADDR_W-1:0]  o_raddr
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ARRAY_SIZE);

    logic [ADDR_W-1:0] r_base, r_off, r_raddr;
    logic              r_ren;
    logic [ADDR_W-1:0] w_base_nxt, w_off_nxt, w_tile_addr, w_raddr_nxt;
    logic              w_ren_nxt;

    // Next base/offset and the address for the cycle being entered (wraps mod 2^ADDR_W)
    always_comb begin
        w_base_nxt  = i_load ? i_base : r_base;
        w_off_nxt   = i_load ? '0 : (i_adv ? r_off + STEP : r_off);
        w_tile_addr = w_base_nxt + w_off_nxt;
        w_ren_nxt   = 1'b0;
        w_raddr_nxt = '0;
        case (i_mode)
            AG_PF: begin
                w_ren_nxt   = 1'b1;
                w_raddr_nxt = w_tile_addr;
            end
            AG_RD: begin
                // one cycle ahead so data for cycle c lands while cycle_num=c
                w_ren_nxt   = 1'b1;
                w_raddr_nxt = w_tile_addr + ADDR_W'(i_cycle) + ADDR_W'(1);
            end
            AG_HOLD: w_raddr_nxt = r_raddr;
            default: ;
        endcase
    end

    // Registered base/offset and SRAM port; reset also clears the latched base
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_off   <= '0;
            r_ren   <= 1'b0;
            r_raddr <= '0;
        end else begin
            r_base  <= w_base_nxt;
            r_off   <= w_off_nxt;
            r_ren   <= w_ren_nxt;
            r_raddr <= w_raddr_nxt;
        end
    end

    assign o_ren   = r_ren;
    assign o_raddr = r_raddr;
endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the 32x32 systolic array: FSM, cycle counter and
// output-diagonal decode. All outputs are registered from next-state values.
module systolic_ctrl
    import tpu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int TILE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [TILE_W-1:0]  cfg_num_tiles,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    output logic               busy,
    output logic               done,
    output logic               sram_ren,
    output logic [ADDR_W-1:0]  sram_raddr,
    output logic               alu_start,
    output logic [CYCLE_W-1:0] cycle_num,
    output logic [IDX_W-1:0]   matrix_index,
    output logic               out_valid,
    output logic [TILE_W-1:0]  tile_idx
);
    state_t             r_state, w_nxt_state;
    logic [TILE_W-1:0]  r_num_tiles, r_tile, w_nxt_tile;
    logic [CYCLE_W-1:0] r_cycle, w_nxt_cycle;
    logic               r_busy, r_done, r_alu, r_ov;
    logic [IDX_W-1:0]   r_midx;
    logic               w_load, w_adv, w_active, w_run, w_valid;
    ag_mode_t           w_mode;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt_state;
    end

    // Next state, counter/tile advance and the decoded values for the next cycle
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cycle = '0;
        w_nxt_tile  = r_tile;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (cfg_num_tiles != '0) begin
                        w_nxt_state = PREFETCH;
                        w_load      = 1'b1;
                        w_nxt_tile  = '0;
                    end else begin
                        w_nxt_state = DONE;
                    end
                end
            end
            PREFETCH: w_nxt_state = RUN;
            RUN: begin
                if (r_cycle == CYCLE_W'(LAST)) begin
                    if (r_tile + TILE_W'(1) < r_num_tiles) begin
                        w_nxt_state = PREFETCH;
                        w_adv       = 1'b1;
                        w_nxt_tile  = r_tile + TILE_W'(1);
                    end else begin
                        w_nxt_state = DONE;
                    end
                end else begin
                    w_nxt_cycle = r_cycle + CYCLE_W'(1);
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
        // abort overrides every transition but is meaningless in IDLE
        if (abort && r_state != IDLE) begin
            w_nxt_state = IDLE;
            w_nxt_cycle = '0;
            w_adv       = 1'b0;
        end
        w_active = (w_nxt_state == PREFETCH) || (w_nxt_state == RUN);
        w_run    = (w_nxt_state == RUN);
        w_valid  = w_run && (w_nxt_cycle >= CYCLE_W'(FIRST_OUT));
        if (w_nxt_state == PREFETCH)
            w_mode = AG_PF;
        else if (w_run)
            w_mode = (w_nxt_cycle < CYCLE_W'(ARRAY_SIZE - 1)) ? AG_RD : AG_HOLD;
        else
            w_mode = AG_OFF;
    end

    // Registered outputs and latched tile count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_tiles <= '0;
            r_tile      <= '0;
            r_cycle     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_alu       <= 1'b0;
            r_ov        <= 1'b0;
            r_midx      <= '0;
        end else begin
            if (w_load) r_num_tiles <= cfg_num_tiles;
            r_tile  <= w_active ? w_nxt_tile : '0;
            r_cycle <= w_run ? w_nxt_cycle : '0;
            r_busy  <= w_active;
            r_done  <= (w_nxt_state == DONE);
            r_alu   <= w_run;
            r_ov    <= w_valid;
            r_midx  <= w_valid ? IDX_W'(w_nxt_cycle - CYCLE_W'(FIRST_OUT)) : '0;
        end
    end

    systolic_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_base  (cfg_base_addr),
        .i_adv   (w_adv),
        .i_mode  (w_mode),
        .i_cycle (w_nxt_cycle),
        .o_ren   (sram_ren),
        .o_raddr (sram_raddr)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign alu_start    = r_alu;
    assign cycle_num    = r_cycle;
    assign matrix_index = r_midx;
    assign out_valid    = r_ov;
    assign tile_idx     = r_tile;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: single tile, multi-tile, empty job,
// abort, ignored mid-job start/config, and reset mid-job with address wrap.
module tb_systolic_ctrl;
    import tpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_num_tiles = '0;
    logic [9:0]  cfg_base_addr = '0;
    logic        busy, done, sram_ren, alu_start, out_valid;
    logic [9:0]  sram_raddr;
    logic [8:0]  cycle_num;
    logic [5:0]  matrix_index;
    logic [7:0]  tile_idx;

    int checks = 0;
    int errors = 0;

    systolic_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_base_addr(cfg_base_addr),
        .busy(busy), .done(done), .sram_ren(sram_ren), .sram_raddr(sram_raddr),
        .alu_start(alu_start), .cycle_num(cycle_num), .matrix_index(matrix_index),
        .out_valid(out_valid), .tile_idx(tile_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Everything quiet; done optionally high for the completion cycle
    task automatic chk_quiet(input string tag, input int exp_done);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, exp_done);
        chk({tag, ".ren"}, sram_ren, 0);
        chk({tag, ".raddr"}, sram_raddr, 0);
        chk({tag, ".alu"}, alu_start, 0);
        chk({tag, ".cyc"}, cycle_num, 0);
        chk({tag, ".ov"}, out_valid, 0);
        chk({tag, ".midx"}, matrix_index, 0);
        chk({tag, ".tile"}, tile_idx, 0);
    endtask

    // One PREFETCH cycle then ncyc RUN cycles (cycle_num 0..ncyc-1)
    task automatic expect_tile(input int pf, input int tile, input int ncyc, input bit poke);
        int nv;
        int ea;
        step();
        start = 1'b0;
        chk("pf.busy", busy, 1);
        chk("pf.ren", sram_ren, 1);
        chk("pf.raddr", sram_raddr, pf % 1024);
        chk("pf.alu", alu_start, 0);
        chk("pf.cyc", cycle_num, 0);
        chk("pf.ov", out_valid, 0);
        chk("pf.tile", tile_idx, tile);
        nv = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (poke && c == 10) begin
                start = 1'b1;
                cfg_base_addr = 10'd500;
                cfg_num_tiles = 8'd5;
            end
            if (poke && c == 11) start = 1'b0;
            step();
            ea = (pf + ((c < 31) ? c + 1 : 31)) % 1024;
            chk("run.alu", alu_start, 1);
            chk("run.busy", busy, 1);
            chk("run.done", done, 0);
            chk("run.cyc", cycle_num, c);
            chk("run.ren", sram_ren, (c < 31) ? 1 : 0);
            chk("run.raddr", sram_raddr, ea);
            chk("run.ov", out_valid, (c >= 33) ? 1 : 0);
            chk("run.midx", matrix_index, (c >= 33) ? c - 33 : 0);
            chk("run.tile", tile_idx, tile);
            nv += int'(out_valid);
        end
        if (ncyc == 97) chk("run.nvalid", nv, 64);
    endtask

    task automatic expect_done();
        step();
        chk_quiet("done", 1);
        step();
        chk_quiet("after_done", 0);
    endtask

    initial begin
        // reset state
        step();
        step();
        chk_quiet("reset", 0);
        rst = 1'b0;
        step();
        chk_quiet("idle", 0);

        // single tile at base 0
        start = 1'b1; cfg_num_tiles = 8'd1; cfg_base_addr = 10'd0;
        expect_tile(0, 0, 97, 1'b0);
        expect_done();

        // three tiles at base 100
        start = 1'b1; cfg_num_tiles = 8'd3; cfg_base_addr = 10'd100;
        expect_tile(100, 0, 97, 1'b0);
        expect_tile(132, 1, 97, 1'b0);
        expect_tile(164, 2, 97, 1'b0);
        expect_done();

        // empty job: done one cycle after start, nothing else
        start = 1'b1; cfg_num_tiles = 8'd0; cfg_base_addr = 10'd9;
        step();
        start = 1'b0;
        chk_quiet("empty", 1);
        step();
        chk_quiet("empty_after", 0);

        // abort at cycle_num=50 of tile 1 of 2
        start = 1'b1; cfg_num_tiles = 8'd2; cfg_base_addr = 10'd0;
        expect_tile(0, 0, 97, 1'b0);
        expect_tile(32, 1, 51, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_quiet("abort", 0);
        chk("abort.state", int'(dut.r_state), int'(IDLE));
        step();
        chk_quiet("abort_after", 0);
        step();
        chk_quiet("abort_after2", 0);

        // new job accepted after abort
        start = 1'b1; cfg_num_tiles = 8'd1; cfg_base_addr = 10'd7;
        expect_tile(7, 0, 97, 1'b0);
        expect_done();

        // start re-pulsed and config changed mid-job: ignored
        start = 1'b1; cfg_num_tiles = 8'd1; cfg_base_addr = 10'd200;
        expect_tile(200, 0, 97, 1'b1);
        expect_done();

        // reset mid-RUN clears outputs and latched config
        start = 1'b1; cfg_num_tiles = 8'd2; cfg_base_addr = 10'd300;
        expect_tile(300, 0, 20, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_quiet("rst_mid", 0);
        chk("rst_mid.ntiles", int'(dut.r_num_tiles), 0);
        chk("rst_mid.base", int'(dut.u_addr.r_base), 0);

        // base 1020, two tiles: second prefetch wraps to 28
        start = 1'b1; cfg_num_tiles = 8'd2; cfg_base_addr = 10'd1020;
        expect_tile(1020, 0, 97, 1'b0);
        expect_tile(1052, 1, 97, 1'b0);
        expect_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
